// File: rtl/hsv2rgb_stream.sv
`default_nettype none
// ============================================================================
// Module   : hsv2rgb_stream
// Brief    : Three-stage pipelined HSV-to-RGB converter with valid/ready
//            handshakes, global brightness scaling, selectable channel order
//            and LED-index / frame-end sideband passthrough.
// Revision : 1.0 - initial release
// ============================================================================
module hsv2rgb_stream #(
  parameter int HSV_DEPTH = 8,
  parameter int RGB_DEPTH = 8,
  parameter int ID_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [HSV_DEPTH-1:0]   in_hue,
  input  logic [HSV_DEPTH-1:0]   in_sat,
  input  logic [HSV_DEPTH-1:0]   in_val,
  input  logic [HSV_DEPTH-1:0]   in_bri,
  input  logic [1:0]             in_order,
  input  logic [ID_WIDTH-1:0]    in_id,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3*RGB_DEPTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]    out_id,
  output logic                   out_last
);

  localparam int H = HSV_DEPTH;
  localparam logic [HSV_DEPTH-1:0] c_max = '1;

  // (a*b) >> H, full-width product so nothing overflows
  function automatic logic [H-1:0] mul_hi(input logic [H-1:0] a, input logic [H-1:0] b);
    logic [2*H-1:0] prod;
    prod = {{H{1'b0}}, a} * {{H{1'b0}}, b};
    return H'(prod >> H);
  endfunction

  // (c*(bri+1)) >> H; bri = all-ones is exact unity
  function automatic logic [H-1:0] scale_bri(input logic [H-1:0] c, input logic [H-1:0] bri);
    logic [2*H-1:0] prod;
    prod = {{H{1'b0}}, c} * ({{H{1'b0}}, bri} + {{(2*H-1){1'b0}}, 1'b1});
    return H'(prod >> H);
  endfunction

  // Keep the top RGB_DEPTH bits (truncation, no rounding)
  function automatic logic [RGB_DEPTH-1:0] to_channel(input logic [H-1:0] c);
    return RGB_DEPTH'(c >> (H - RGB_DEPTH));
  endfunction

  // Whole pipeline moves together; a stalled output freezes every stage
  logic advance;
  assign advance  = ~out_valid | out_ready;
  // Reset empties the pipe, so the converter is always ready during reset;
  // the stage registers ignore in_valid while rst is high.
  assign in_ready = advance | rst;

  // ---------------- Stage 1: sector/fraction split and sideband capture
  logic [H+2:0]          w_hue_x6;
  logic                  s1_valid_d, s1_valid_q;
  logic [2:0]            s1_sector_d, s1_sector_q;
  logic [H-1:0]          s1_frac_d, s1_frac_q;
  logic [H-1:0]          s1_sat_d, s1_sat_q;
  logic [H-1:0]          s1_val_d, s1_val_q;
  logic [H-1:0]          s1_bri_d, s1_bri_q;
  logic [1:0]            s1_order_d, s1_order_q;
  logic [ID_WIDTH-1:0]   s1_id_d, s1_id_q;
  logic                  s1_last_d, s1_last_q;

  // hue*6 = hue*4 + hue*2; integer part is the sector, low H bits the fraction
  assign w_hue_x6 = {1'b0, in_hue, 2'b00} + {2'b00, in_hue, 1'b0};

  // Stage 1 next-state: load a new pixel on advance, else hold
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sector_d = s1_sector_q;
    s1_frac_d   = s1_frac_q;
    s1_sat_d    = s1_sat_q;
    s1_val_d    = s1_val_q;
    s1_bri_d    = s1_bri_q;
    s1_order_d  = s1_order_q;
    s1_id_d     = s1_id_q;
    s1_last_d   = s1_last_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s1_sector_d = w_hue_x6[H+2:H];
      s1_frac_d   = w_hue_x6[H-1:0];
      s1_sat_d    = in_sat;
      s1_val_d    = in_val;
      s1_bri_d    = in_bri;
      s1_order_d  = in_order;
      s1_id_d     = in_id;
      s1_last_d   = in_last;
    end
  end

  // ---------------- Stage 2: p/q/t and sector-based channel selection
  logic [H-1:0]          w_p, w_q, w_t, w_r, w_g, w_b;
  logic                  s2_valid_d, s2_valid_q;
  logic [H-1:0]          s2_r_d, s2_r_q, s2_g_d, s2_g_q, s2_b_d, s2_b_q;
  logic [H-1:0]          s2_bri_d, s2_bri_q;
  logic [1:0]            s2_order_d, s2_order_q;
  logic [ID_WIDTH-1:0]   s2_id_d, s2_id_q;
  logic                  s2_last_d, s2_last_q;

  // Colour wheel arithmetic and sector mapping to {R,G,B}
  always_comb begin
    w_p = mul_hi(s1_val_q, c_max - s1_sat_q);
    w_q = mul_hi(s1_val_q, c_max - mul_hi(s1_sat_q, s1_frac_q));
    w_t = mul_hi(s1_val_q, c_max - mul_hi(s1_sat_q, c_max - s1_frac_q));
    case (s1_sector_q)
      3'd0:    begin w_r = s1_val_q; w_g = w_t;      w_b = w_p;      end
      3'd1:    begin w_r = w_q;      w_g = s1_val_q; w_b = w_p;      end
      3'd2:    begin w_r = w_p;      w_g = s1_val_q; w_b = w_t;      end
      3'd3:    begin w_r = w_p;      w_g = w_q;      w_b = s1_val_q; end
      3'd4:    begin w_r = w_t;      w_g = w_p;      w_b = s1_val_q; end
      default: begin w_r = s1_val_q; w_g = w_p;      w_b = w_q;      end
    endcase
  end

  // Stage 2 next-state: load on advance, else hold
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_r_d     = s2_r_q;
    s2_g_d     = s2_g_q;
    s2_b_d     = s2_b_q;
    s2_bri_d   = s2_bri_q;
    s2_order_d = s2_order_q;
    s2_id_d    = s2_id_q;
    s2_last_d  = s2_last_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_r_d     = w_r;
      s2_g_d     = w_g;
      s2_b_d     = w_b;
      s2_bri_d   = s1_bri_q;
      s2_order_d = s1_order_q;
      s2_id_d    = s1_id_q;
      s2_last_d  = s1_last_q;
    end
  end

  // ---------------- Stage 3: brightness scaling and channel packing
  logic [RGB_DEPTH-1:0]   w_rc, w_gc, w_bc;
  logic [3*RGB_DEPTH-1:0] w_packed;
  logic                   s3_valid_d, s3_valid_q;
  logic [3*RGB_DEPTH-1:0] s3_data_d, s3_data_q;
  logic [ID_WIDTH-1:0]    s3_id_d, s3_id_q;
  logic                   s3_last_d, s3_last_q;

  // Scale each channel, then order it with the first-named channel in the MSBs
  always_comb begin
    w_rc = to_channel(scale_bri(s2_r_q, s2_bri_q));
    w_gc = to_channel(scale_bri(s2_g_q, s2_bri_q));
    w_bc = to_channel(scale_bri(s2_b_q, s2_bri_q));
    case (s2_order_q)
      2'd0:    w_packed = {w_rc, w_gc, w_bc};
      2'd1:    w_packed = {w_gc, w_rc, w_bc};
      2'd2:    w_packed = {w_bc, w_rc, w_gc};
      default: w_packed = {w_rc, w_bc, w_gc};
    endcase
  end

  // Stage 3 next-state: load on advance, else hold the presented pixel
  always_comb begin
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_id_d    = s3_id_q;
    s3_last_d  = s3_last_q;
    if (advance) begin
      s3_valid_d = s2_valid_q;
      s3_data_d  = w_packed;
      s3_id_d    = s2_id_q;
      s3_last_d  = s2_last_q;
    end
  end

  // All pipeline state; reset clears valids and data so nothing in flight survives
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sector_q <= '0;
      s1_frac_q   <= '0;
      s1_sat_q    <= '0;
      s1_val_q    <= '0;
      s1_bri_q    <= '0;
      s1_order_q  <= '0;
      s1_id_q     <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_r_q      <= '0;
      s2_g_q      <= '0;
      s2_b_q      <= '0;
      s2_bri_q    <= '0;
      s2_order_q  <= '0;
      s2_id_q     <= '0;
      s2_last_q   <= 1'b0;
      s3_valid_q  <= 1'b0;
      s3_data_q   <= '0;
      s3_id_q     <= '0;
      s3_last_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sector_q <= s1_sector_d;
      s1_frac_q   <= s1_frac_d;
      s1_sat_q    <= s1_sat_d;
      s1_val_q    <= s1_val_d;
      s1_bri_q    <= s1_bri_d;
      s1_order_q  <= s1_order_d;
      s1_id_q     <= s1_id_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_r_q      <= s2_r_d;
      s2_g_q      <= s2_g_d;
      s2_b_q      <= s2_b_d;
      s2_bri_q    <= s2_bri_d;
      s2_order_q  <= s2_order_d;
      s2_id_q     <= s2_id_d;
      s2_last_q   <= s2_last_d;
      s3_valid_q  <= s3_valid_d;
      s3_data_q   <= s3_data_d;
      s3_id_q     <= s3_id_d;
      s3_last_q   <= s3_last_d;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_data  = s3_data_q;
  assign out_id    = s3_id_q;
  assign out_last  = s3_last_q;

endmodule
`default_nettype wire

// File: tb/tb_hsv2rgb_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsv2rgb_stream
// Brief    : Directed self-checking bench for hsv2rgb_stream (8-bit defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hsv2rgb_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_hue, in_sat, in_val, in_bri;
  logic [1:0]  in_order;
  logic [7:0]  in_id;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [7:0]  out_id;
  logic        out_last;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  h;
    logic [7:0]  s;
    logic [7:0]  v;
    logic [7:0]  b;
    logic [1:0]  o;
    logic [23:0] exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  hsv2rgb_stream #(
    .HSV_DEPTH(8),
    .RGB_DEPTH(8),
    .ID_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_hue   (in_hue),
    .in_sat   (in_sat),
    .in_val   (in_val),
    .in_bri   (in_bri),
    .in_order (in_order),
    .in_id    (in_id),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id),
    .out_last (out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [7:0] id, input logic last);
    in_hue   = vecs[idx].h;
    in_sat   = vecs[idx].s;
    in_val   = vecs[idx].v;
    in_bri   = vecs[idx].b;
    in_order = vecs[idx].o;
    in_id    = id;
    in_last  = last;
  endtask

  // Sends one pixel into an idle pipe, returns what emerges and after how many edges
  task automatic convert(input int idx, input logic [7:0] id, input logic last,
                         output logic [23:0] data, output logic [7:0] oid,
                         output logic olast, output int lat);
    out_ready = 1'b1;
    drive(idx, id, last);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    data  = out_data;
    oid   = out_id;
    olast = out_last;
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, 8'h55, 1'b1);
    in_valid = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", out_data); end
    n_cmp++; if (out_id !== 8'h0) begin n_fail++; $display("FAIL reset_id: got %h want 00", out_id); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: got out_valid seen=%b want 0", seen); end
  endtask

  task automatic test_colors();
    logic [23:0] d;
    logic [7:0]  oid;
    logic        olast;
    int          lat;
    for (int i = 0; i < NVEC; i++) begin
      convert(i, 8'(i + 8'h40), i[0], d, oid, olast, lat);
      n_cmp++; if (d !== vecs[i].exp) begin n_fail++; $display("FAIL color[%0d]: got %h want %h", i, d, vecs[i].exp); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL latency[%0d]: got %0d want 3", i, lat); end
      n_cmp++; if (oid !== 8'(i + 8'h40) || olast !== i[0]) begin
        n_fail++; $display("FAIL sideband[%0d]: got id=%h last=%b want id=%h last=%b", i, oid, olast, 8'(i + 8'h40), i[0]);
      end
    end
  endtask

  // Order changes on a single pixel must not leak to its neighbours
  task automatic test_back_to_back();
    logic [1:0]  ords [3];
    logic [23:0] exps [3];
    ords[0] = 2'd0; ords[1] = 2'd1; ords[2] = 2'd0;
    exps[0] = 24'hFF0000; exps[1] = 24'h00FF00; exps[2] = 24'hFF0000;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(0, 8'(8'h30 + k), 1'b0);
      in_order = ords[k];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exps[k] || out_id !== 8'(8'h30 + k)) begin
        n_fail++; $display("FAIL b2b[%0d]: got valid=%b data=%h id=%h want valid=1 data=%h id=%h", k, out_valid, out_data, out_id, exps[k], 8'(8'h30 + k));
      end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_stream();
    int          sent, rcvd, cyc;
    logic        hold, hlast;
    logic [23:0] hd;
    logic [7:0]  hid;
    logic        seen;
    sent = 0; rcvd = 0; cyc = 0; hold = 1'b0;
    hd = '0; hid = '0; hlast = 1'b0;
    while (rcvd < 16 && cyc < 500) begin
      if (hold) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== hd || out_id !== hid || out_last !== hlast) begin
          n_fail++; $display("FAIL stream_hold: got valid=%b data=%h id=%h last=%b want valid=1 data=%h id=%h last=%b", out_valid, out_data, out_id, out_last, hd, hid, hlast);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16) begin
        drive(sent % NVEC, sent[7:0], sent == 15);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      hold = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_data !== vecs[rcvd % NVEC].exp) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", rcvd, out_data, vecs[rcvd % NVEC].exp); end
        n_cmp++; if (out_id !== rcvd[7:0]) begin n_fail++; $display("FAIL stream_id[%0d]: got %h want %h", rcvd, out_id, rcvd[7:0]); end
        n_cmp++; if (out_last !== (rcvd == 15)) begin n_fail++; $display("FAIL stream_last[%0d]: got %b want %b", rcvd, out_last, rcvd == 15); end
        rcvd++;
      end else if (out_valid) begin
        hold = 1'b1; hd = out_data; hid = out_id; hlast = out_last;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    n_cmp++; if (rcvd !== 16) begin n_fail++; $display("FAIL stream_count: got %0d want 16", rcvd); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stream_extra: got extra output=%b want 0", seen); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    // A, B, C fill the pipe while the output side is blocked
    drive(0, 8'h10, 1'b0); in_valid = 1'b1; tick();
    drive(2, 8'h11, 1'b0); tick();
    drive(3, 8'h12, 1'b0); tick();
    drive(5, 8'h13, 1'b1);
    #1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'hFF0000 || out_id !== 8'h10 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_frozen[%0d]: got valid=%b data=%h id=%h in_ready=%b want valid=1 data=ff0000 id=10 in_ready=0", c, out_valid, out_data, out_id, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready0: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'h01FF00 || out_id !== 8'h11 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_b: got valid=%b data=%h id=%h in_ready=%b want valid=1 data=01ff00 id=11 in_ready=1", out_valid, out_data, out_id, in_ready);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'hFF0005 || out_id !== 8'h12 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_c: got valid=%b data=%h id=%h in_ready=%b want valid=1 data=ff0005 id=12 in_ready=1", out_valid, out_data, out_id, in_ready);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 24'hC8C7C7 || out_id !== 8'h13 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL release_d: got valid=%b data=%h id=%h last=%b want valid=1 data=c8c7c7 id=13 last=1", out_valid, out_data, out_id, out_last);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    logic        seen;
    logic [23:0] d;
    logic [7:0]  oid;
    logic        olast;
    int          lat;
    out_ready = 1'b1;
    drive(2, 8'h20, 1'b0); in_valid = 1'b1; tick();
    drive(3, 8'h21, 1'b1); tick();
    drive(0, 8'h22, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 24'h0 || out_id !== 8'h0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_clear: got valid=%b data=%h id=%h last=%b want all zero", out_valid, out_data, out_id, out_last);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_discard: got stale output=%b want 0", seen); end
    convert(4, 8'h23, 1'b0, d, oid, olast, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL mid_reset_latency: got %0d want 3", lat); end
    n_cmp++; if (d !== 24'h7F0000 || oid !== 8'h23) begin n_fail++; $display("FAIL mid_reset_pixel: got data=%h id=%h want data=7f0000 id=23", d, oid); end
  endtask

  initial begin
    vecs[0]  = '{8'd0,   8'd255, 8'd255, 8'd255, 2'd0, 24'hFF0000};
    vecs[1]  = '{8'd0,   8'd255, 8'd255, 8'd255, 2'd1, 24'h00FF00};
    vecs[2]  = '{8'd85,  8'd255, 8'd255, 8'd255, 2'd0, 24'h01FF00};
    vecs[3]  = '{8'd255, 8'd255, 8'd255, 8'd255, 2'd0, 24'hFF0005};
    vecs[4]  = '{8'd0,   8'd255, 8'd255, 8'd127, 2'd0, 24'h7F0000};
    vecs[5]  = '{8'd0,   8'd0,   8'd200, 8'd255, 2'd0, 24'hC8C7C7};
    vecs[6]  = '{8'd100, 8'd200, 8'd0,   8'd255, 2'd0, 24'h000000};
    vecs[7]  = '{8'd85,  8'd255, 8'd255, 8'd255, 2'd2, 24'h0001FF};
    vecs[8]  = '{8'd85,  8'd255, 8'd255, 8'd255, 2'd3, 24'h0100FF};
    vecs[9]  = '{8'd0,   8'd255, 8'd255, 8'd0,   2'd0, 24'h000000};
    vecs[10] = '{8'd0,   8'd255, 8'd255, 8'd128, 2'd0, 24'h800000};
    vecs[11] = '{8'd128, 8'd255, 8'd255, 8'd255, 2'd0, 24'h00FEFF};
    vecs[12] = '{8'd43,  8'd255, 8'd255, 8'd255, 2'd0, 24'hFDFF00};
    vecs[13] = '{8'd170, 8'd255, 8'd255, 8'd255, 2'd0, 24'h0003FF};
    vecs[14] = '{8'd100, 8'd128, 8'd200, 8'd255, 2'd0, 24'h63C886};
    vecs[15] = '{8'd100, 8'd128, 8'd200, 8'd127, 2'd0, 24'h316443};
    vecs[16] = '{8'd200, 8'd255, 8'd255, 8'd255, 2'd0, 24'hB000FF};
    vecs[17] = '{8'd20,  8'd255, 8'd255, 8'd255, 2'd0, 24'hFF7800};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_hue = '0; in_sat = '0; in_val = '0; in_bri = '0;
    in_order = '0; in_id = '0; in_last = 1'b0;

    test_reset();
    test_colors();
    test_back_to_back();
    test_stream();
    test_stall();
    test_reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hsv2rgb_stream.md
Name: hsv2rgb_stream

Overview:
- Pipelined, parametrised HSV-to-RGB colour converter with valid/ready handshakes on both sides.
- Adds a per-pixel global brightness scale, a runtime-selectable output channel order, and LED-index/frame-end sideband passthrough.
- Sits between the pattern/animation generator and the WS2812 serialiser. One pixel per clock at full throughput.

Parameters:
- HSV_DEPTH, 8, width of hue/sat/val/bri inputs. Legal range 4..12.
- RGB_DEPTH, 8, width of each output colour channel. Must satisfy RGB_DEPTH <= HSV_DEPTH.
- ID_WIDTH, 8, width of the LED index sideband.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  converter can accept a pixel this cycle
- in_hue  in  HSV_DEPTH  hue; full range maps to 0..360°
- in_sat  in  HSV_DEPTH  saturation
- in_val  in  HSV_DEPTH  value
- in_bri  in  HSV_DEPTH  brightness scale; all-ones = unity
- in_order  in  2  output packing: 0=RGB, 1=GRB, 2=BRG, 3=RBG
- in_id  in  ID_WIDTH  LED index, passed through unchanged
- in_last  in  1  last pixel of frame, passed through unchanged
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts the pixel
- out_data  out  3*RGB_DEPTH  packed colour; first-named channel in MSBs
- out_id  out  ID_WIDTH  LED index
- out_last  out  1  frame end

Behaviour:
- Arithmetic (H=HSV_DEPTH, M=2^H-1; all products full width, no overflow):
  - Sector and fraction: x = hue*6; sector = x>>H (0..5); f = x[H-1:0].
  - p = (val*(M-sat))>>H
  - q = (val*(M-((sat*f)>>H)))>>H
  - t = (val*(M-((sat*(M-f))>>H)))>>H
  - Sector mapping {R,G,B}: 0:{val,t,p} 1:{q,val,p} 2:{p,val,t} 3:{p,q,val} 4:{t,p,val} 5:{val,p,q}.
  - Brightness: c' = (c*(bri+1))>>H for each channel.
  - Output channel = c'[H-1 -: RGB_DEPTH] (truncation, no rounding).
- Pipeline: 3 register stages; latency exactly 3 cycles from input accept to out_valid when not stalled.
  - S1: registers sector, f, sat, val, bri, order, id, last.
  - S2: registers p, q, t, R/G/B selection.
  - S3: registers brightness scaling and order packing.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - Every stage register loads only when advance=1. A stage's valid bit loads the previous stage's valid bit, or in_valid at S1.
  - A pixel is accepted when in_valid & in_ready.
  - Output is held stable while out_valid & !out_ready: out_data, out_id and out_last must not change.
  - Bubbles are not compressed: a stall freezes the whole pipeline, including empty slots.
  - Simultaneous output transfer and input accept in one cycle is legal; sustained throughput is 1 pixel/clk.
- in_order is sampled with its pixel. A per-pixel change takes effect only on that pixel; the pixel before and after are unaffected.
- Reset:
  - rst=1 clears all stage valids and data registers to 0 next edge: out_valid=0, out_data=0, out_id=0, out_last=0.
  - in_ready=1 during reset and after it.
  - Reset mid-stream discards all in-flight pixels with no partial output.
  - While rst=1, input is not accepted even if in_valid=1.
- Boundaries:
  - hue=M lands in sector 5.
  - sat=0 gives p=q=t=(val*M)>>H; with H=8 this is val-1 for val>0, i.e. greys differ by 1 LSB between channels.
  - bri=M is exact unity; bri=0 halves nothing: scale is (bri+1)/2^H.
  - val=0 outputs all zero.
  - Input values are don't-care when in_valid=0.

Test Plan:
- Defaults, order=0, hue=0, sat=255, val=255, bri=255 -> after 3 cycles out_data=0xFF0000. Same pixel with order=1 -> 0x00FF00.
- hue=85, sat=255, val=255, bri=255, order=0 -> 0x01FF00. hue=255 -> 0xFF0005.
- hue=0, sat=255, val=255, bri=127 -> R=0x7F. Same with sat=0, val=200, bri=255 -> 0xC8C7C7.
- Stream 16 pixels, id 0..15, last on id 15, out_ready random 50% -> all 16 emerge in order with correct id/last. Data stable whenever out_valid & !out_ready; no loss or duplication.
- out_ready held low with 3 pixels in flight -> in_ready=0, outputs frozen. Release -> 1 pixel/clk, in_ready=1 each cycle.
- Assert rst for 1 cycle with 2 pixels in flight -> next cycle out_valid=0 and out_data=0. Those pixels never appear; a new pixel is output 3 cycles after its accept.
